seg7_scan_reader: RTL and testbench

Receive-side counterpart to the hex-to-7-segment encoding: samples an externally multiplexed 7-segment display bus (segment lines plus one-hot digit strobes), filters settling glitches and recovers each digit's 4-bit hex value. Sits at the board-input boundary and feeds the recovered digits to the logic-analyser/readback path as a packed register with per-digit valid flags.

---
 rtl/seg7_pkg.sv | 57 +++++
 rtl/seg7_pattern_decode.sv | 51 +++++
 rtl/seg7_scan_reader.sv | 116 +++++++++++
 tb/tb_seg7_scan_reader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the 7-segment scan reader:
//   - segment bit positions on the seg_in bus (a = bit 6 ... g = bit 0)
//   - the sixteen glyph patterns (0..9, A, b, C, d, E, F) and the blank pattern
//   - the scan FSM state type and a one-hot helper
// Configuration macro consumed downstream: SEG7_READER_A2F_EN (enables A..F decode).
package seg7_pkg;

  // Segment bit positions on the 7-bit segment bus.
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] M_A = 7'(1 << SEG_A);
  localparam logic [6:0] M_B = 7'(1 << SEG_B);
  localparam logic [6:0] M_C = 7'(1 << SEG_C);
  localparam logic [6:0] M_D = 7'(1 << SEG_D);
  localparam logic [6:0] M_E = 7'(1 << SEG_E);
  localparam logic [6:0] M_F = 7'(1 << SEG_F);
  localparam logic [6:0] M_G = 7'(1 << SEG_G);

  // Glyphs built from their lit segments so the hex values can be read back
  // against a drawing of the display.
  localparam logic [6:0] PAT_0 = M_A | M_B | M_C | M_D | M_E | M_F;        // 7E
  localparam logic [6:0] PAT_1 = M_B | M_C;                                // 30
  localparam logic [6:0] PAT_2 = M_A | M_B | M_D | M_E | M_G;              // 6D
  localparam logic [6:0] PAT_3 = M_A | M_B | M_C | M_D | M_G;              // 79
  localparam logic [6:0] PAT_4 = M_B | M_C | M_F | M_G;                    // 33
  localparam logic [6:0] PAT_5 = M_A | M_C | M_D | M_F | M_G;              // 5B
  localparam logic [6:0] PAT_6 = M_A | M_C | M_D | M_E | M_F | M_G;        // 5F
  localparam logic [6:0] PAT_7 = M_A | M_B | M_C;                          // 70
  localparam logic [6:0] PAT_8 = M_A | M_B | M_C | M_D | M_E | M_F | M_G;  // 7F
  localparam logic [6:0] PAT_9 = M_A | M_B | M_C | M_D | M_F | M_G;        // 7B
  localparam logic [6:0] PAT_A = M_A | M_B | M_C | M_E | M_F | M_G;        // 77
  localparam logic [6:0] PAT_B = M_C | M_D | M_E | M_F | M_G;              // 1F
  localparam logic [6:0] PAT_C = M_A | M_D | M_E | M_F;                    // 4E
  localparam logic [6:0] PAT_D = M_B | M_C | M_D | M_E | M_G;              // 3D
  localparam logic [6:0] PAT_E = M_A | M_D | M_E | M_F | M_G;              // 4F
  localparam logic [6:0] PAT_F = M_A | M_E | M_F | M_G;                    // 47
  localparam logic [6:0] PAT_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HELD
  } scan_state_t;

  // True when exactly one bit of the (zero-extended) strobe word is set.
  function automatic logic is_one_hot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode
// Combinational lookup from a 7-segment pattern to its hex value.
// Ports:
//   pattern  in  7  segment word, a = bit 6 ... g = bit 0
//   known    out 1  pattern is a recognised glyph
//   blank    out 1  pattern is all segments off
//   hex      out 4  value of a recognised glyph (0 otherwise)
// Macro SEG7_READER_A2F_EN: when defined, A/b/C/d/E/F decode to 0xA..0xF;
// otherwise only 0..9 are recognised and the letter glyphs count as unknown.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       known,
  output logic       blank,
  output logic [3:0] hex
);

  // Exact match only: a glyph with one stray or missing segment is unknown.
  always_comb begin
    known = 1'b1;
    blank = 1'b0;
    hex   = 4'h0;
    case (pattern)
      PAT_0: hex = 4'h0;
      PAT_1: hex = 4'h1;
      PAT_2: hex = 4'h2;
      PAT_3: hex = 4'h3;
      PAT_4: hex = 4'h4;
      PAT_5: hex = 4'h5;
      PAT_6: hex = 4'h6;
      PAT_7: hex = 4'h7;
      PAT_8: hex = 4'h8;
      PAT_9: hex = 4'h9;
`ifdef SEG7_READER_A2F_EN
      PAT_A: hex = 4'hA;
      PAT_B: hex = 4'hB;
      PAT_C: hex = 4'hC;
      PAT_D: hex = 4'hD;
      PAT_E: hex = 4'hE;
      PAT_F: hex = 4'hF;
`endif
      PAT_BLANK: begin
        known = 1'b0;
        blank = 1'b1;
      end
      default: known = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader
// Samples a multiplexed 7-segment display bus, waits for each strobe/pattern
// combination to settle, and recovers the hex value shown on each digit.
// Ports:
//   clk          in   1         system clock (rising edge)
//   rst_n        in   1         asynchronous active-low reset
//   seg_in       in   7         segment lines, a = bit 6 ... g = bit 0 (async)
//   dig_en       in   DIGITS    one-hot digit strobes (async)
//   hex_out      out  4*DIGITS  digit i value in bits [4i+3:4i]
//   digit_valid  out  DIGITS    digit i holds a decoded value
//   frame_done   out  1         pulse after a capture on the last digit
//   seg_err      out  1         pulse on unknown glyph or bad strobe word
// Macro SEG7_READER_A2F_EN: enables A..F decode (see seg7_pattern_decode).
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_en,
  output logic [4*DIGITS-1:0]   hex_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  frame_done,
  output logic                  seg_err
);

  localparam int SW = 7 + DIGITS;
  // The counter reads 0 on the first cycle after a change is seen, and the
  // change itself is only visible one cycle after S takes the new value, so
  // a window of STABLE_CYCLES samples completes when the count hits N-2.
  localparam logic [7:0] CAPTURE_COUNT = 8'(STABLE_CYCLES - 2);

  logic [SW-1:0]     sync_meta;
  logic [SW-1:0]     sample;
  logic [SW-1:0]     prev_sample;
  logic [7:0]        stable_cnt;
  scan_state_t       state;

  logic [6:0]        sample_seg;
  logic [DIGITS-1:0] sample_dig;
  logic              changed;
  logic              capture;
  logic              dec_known;
  logic              dec_blank;
  logic [3:0]        dec_hex;

  assign sample_seg = sample[6:0];
  assign sample_dig = sample[SW-1:7];
  assign changed    = (sample != prev_sample);
  assign capture    = (state == ST_SETTLE) && !changed &&
                      (sample_dig != '0) && (stable_cnt == CAPTURE_COUNT);

  seg7_pattern_decode u_decode (
    .pattern (sample_seg),
    .known   (dec_known),
    .blank   (dec_blank),
    .hex     (dec_hex)
  );

  // Synchronizer, stability counter, scan FSM and digit registers.
  // HELD blocks repeat captures until S moves again, so a long stable
  // window produces exactly one update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta   <= '0;
      sample      <= '0;
      prev_sample <= '0;
      stable_cnt  <= 8'd0;
      state       <= ST_IDLE;
      hex_out     <= '0;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      seg_err     <= 1'b0;
    end else begin
      sync_meta   <= {dig_en, seg_in};
      sample      <= sync_meta;
      prev_sample <= sample;
      frame_done  <= 1'b0;
      seg_err     <= 1'b0;

      if (changed) begin
        stable_cnt <= 8'd0;
      end else if (stable_cnt != 8'hFF) begin
        stable_cnt <= stable_cnt + 8'd1;
      end

      if (sample_dig == '0) begin
        state <= ST_IDLE;
      end else if (changed) begin
        state <= ST_SETTLE;
      end else if (capture) begin
        state <= ST_HELD;
        if (is_one_hot(8'(sample_dig))) begin
          for (int i = 0; i < DIGITS; i++) begin
            if (sample_dig[i]) begin
              if (dec_known) begin
                hex_out[4*i +: 4] <= dec_hex;
                digit_valid[i]    <= 1'b1;
              end else begin
                digit_valid[i]    <= 1'b0;
                seg_err           <= !dec_blank;
              end
            end
          end
          frame_done <= sample_dig[DIGITS-1];
        end else begin
          seg_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader
// Directed test-plan steps followed by randomized strobe/pattern holds. A
// reference model tracks runs of identical pin samples and applies each
// completed window's effect two clock edges later; every cycle the DUT
// outputs are compared against the model.
module tb_seg7_scan_reader;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;
  localparam int SW     = 7 + DIGITS;
`ifdef SEG7_READER_A2F_EN
  localparam int NUM_KNOWN = 16;
`else
  localparam int NUM_KNOWN = 10;
`endif

  logic                clk    = 1'b0;
  logic                rst_n  = 1'b0;
  logic [6:0]          seg_in = 7'h00;
  logic [DIGITS-1:0]   dig_en = '0;
  logic [4*DIGITS-1:0] hex_out;
  logic [DIGITS-1:0]   digit_valid;
  logic                frame_done;
  logic                seg_err;

  int checks = 0;
  int errors = 0;

  seg7_scan_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_en      (dig_en),
    .hex_out     (hex_out),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .seg_err     (seg_err)
  );

  always #5 clk = ~clk;

  // Glyph table indexed by value.
  logic [6:0] pattern_table [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
                                     7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h77, 7'h1F,
                                     7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Reference model state.
  logic [3:0]        m_hex [DIGITS];
  logic [DIGITS-1:0] m_valid;
  logic              m_frame;
  logic              m_err;
  logic [SW-1:0]     run_val;
  int                run_len;
  logic              pend_v [2];
  logic [SW-1:0]     pend_s [2];

  function automatic int lookup(input logic [6:0] p);
    int r = -1;
    for (int v = 0; v < NUM_KNOWN; v++)
      if (pattern_table[v] == p) r = v;
    return r;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < DIGITS; i++) m_hex[i] = 4'h0;
    m_valid = '0;
    m_frame = 1'b0;
    m_err   = 1'b0;
    run_val = '0;
    run_len = 0;
    for (int k = 0; k < 2; k++) begin
      pend_v[k] = 1'b0;
      pend_s[k] = '0;
    end
  endtask

  // Effect of one completed stable window.
  task automatic modelApply(input logic [SW-1:0] s);
    logic [6:0]        sg;
    logic [DIGITS-1:0] dg;
    int                v;
    sg = s[6:0];
    dg = s[SW-1:7];
    if ($countones(dg) != 1) begin
      m_err = 1'b1;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (dg[i]) begin
          v = lookup(sg);
          if (v >= 0) begin
            m_hex[i]   = v[3:0];
            m_valid[i] = 1'b1;
          end else begin
            m_valid[i] = 1'b0;
            if (sg != 7'h00) m_err = 1'b1;
          end
          if (i == DIGITS - 1) m_frame = 1'b1;
        end
      end
    end
  endtask

  // One rising edge: the pins seen at this edge extend or restart the run,
  // and a window that reached STABLE samples shows up two edges later.
  task automatic modelEdge();
    logic [SW-1:0] cur;
    cur     = {dig_en, seg_in};
    m_frame = 1'b0;
    m_err   = 1'b0;
    if (pend_v[1]) modelApply(pend_s[1]);
    pend_v[1] = pend_v[0];
    pend_s[1] = pend_s[0];
    if (cur == run_val) begin
      run_len++;
    end else begin
      run_val = cur;
      run_len = 1;
    end
    pend_v[0] = (run_len == STABLE) && (cur[SW-1:7] != '0);
    pend_s[0] = cur;
  endtask

  task automatic check1(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [4*DIGITS-1:0] exp_hex;
    for (int i = 0; i < DIGITS; i++) exp_hex[4*i +: 4] = m_hex[i];
    check1("hex_out", 32'(hex_out), 32'(exp_hex));
    check1("digit_valid", 32'(digit_valid), 32'(m_valid));
    check1("frame_done", 32'(frame_done), 32'(m_frame));
    check1("seg_err", 32'(seg_err), 32'(m_err));
  endtask

  // Hold one pin value for a number of clock edges, checking every cycle.
  task automatic applyStimulus(input logic [6:0] seg, input logic [DIGITS-1:0] dig,
                               input int cycles);
    for (int c = 0; c < cycles; c++) begin
      seg_in = seg;
      dig_en = dig;
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      checkOutput();
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic pulseReset();
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [6:0]        rseg;
    logic [DIGITS-1:0] rdig;
    int                pick;

    $display("[TB] start, DIGITS=%0d STABLE_CYCLES=%0d", DIGITS, STABLE);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkOutput();
    rst_n = 1'b1;

    // Digit 0 shows 5: no update after 5 edges, update on the 6th.
    applyStimulus(7'h5B, 4'b0001, 5);
    check1("latency_not_yet", 32'(digit_valid), 32'h0);
    applyStimulus(7'h5B, 4'b0001, 5);
    check1("digit0_is_5", 32'(hex_out[3:0]), 32'h5);
    check1("digit0_valid", 32'(digit_valid), 32'h1);

    // Full scan 0,1,2,3.
    applyStimulus(7'h7E, 4'b0001, 8);
    applyStimulus(7'h30, 4'b0010, 8);
    applyStimulus(7'h6D, 4'b0100, 8);
    applyStimulus(7'h79, 4'b1000, 8);
    check1("scan_hex", 32'(hex_out), 32'h3210);
    check1("scan_valid", 32'(digit_valid), 32'hF);

    // Digit 2 flickers 8/9 faster than the window, then settles on 9.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(7'h7F, 4'b0100, 3);
      applyStimulus(7'h7B, 4'b0100, 3);
    end
    check1("flicker_no_capture", 32'(hex_out[11:8]), 32'h2);
    applyStimulus(7'h7B, 4'b0100, 8);
    check1("flicker_settled", 32'(hex_out[11:8]), 32'h9);

    // Letter A on digit 1.
    applyStimulus(7'h77, 4'b0010, 8);
`ifdef SEG7_READER_A2F_EN
    check1("letter_a_value", 32'(hex_out[7:4]), 32'hA);
    check1("letter_a_valid", 32'(digit_valid[1]), 32'h1);
`else
    check1("letter_a_kept", 32'(hex_out[7:4]), 32'h1);
    check1("letter_a_invalid", 32'(digit_valid[1]), 32'h0);
`endif

    // Two strobes at once, then a blank on digit 0.
    applyStimulus(7'h30, 4'b0011, 8);
    applyStimulus(7'h00, 4'b0001, 8);
    check1("blank_invalid", 32'(digit_valid[0]), 32'h0);
    check1("blank_kept", 32'(hex_out[3:0]), 32'h0);

    // Reset in the middle of a settle window on digit 0.
    applyStimulus(7'h79, 4'b0001, 3);
    pulseReset();
    applyStimulus(7'h79, 4'b0001, 3);
    check1("post_reset_no_capture", 32'(digit_valid), 32'h0);
    applyStimulus(7'h79, 4'b0001, 6);
    check1("post_reset_capture", 32'(hex_out[3:0]), 32'h3);

    // Randomized holds over strobes and glyphs.
    for (int n = 0; n < 60; n++) begin
      pick = $urandom_range(0, 7);
      if (pick < 4)       rdig = 4'(1 << pick);
      else if (pick == 4) rdig = '0;
      else if (pick == 5) rdig = 4'($urandom_range(0, 15));
      else                rdig = 4'(1 << $urandom_range(0, 3));
      pick = $urandom_range(0, 9);
      if (pick < 7)       rseg = pattern_table[$urandom_range(0, 15)];
      else if (pick == 7) rseg = 7'h00;
      else                rseg = 7'($urandom_range(0, 127));
      applyStimulus(rseg, rdig, $urandom_range(1, 9));
    end
    applyStimulus(7'h00, '0, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
